rd_req_arbiter: RTL

- Shares the single CCI-P read request channel (c0Tx, 4-line requests) among NUM_ACCS accelerator read ports.
- Sits between the per-accelerator read engines and the acc_management read port.
- Round-robin arbitration, per-requester outstanding-line limiting, mdata tagging, and routing of read responses back to the issuing requester by tag.

---
 rtl/rd_req_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/rd_req_arbiter.sv
// Round-robin arbiter sharing one 4-line read request channel among NUM_ACCS requesters,
// with per-requester outstanding-line limits, mdata tagging and tag-based response routing.
module rd_req_arbiter #(
  parameter int NUM_ACCS      = 4,
  parameter int ID_W          = 4,
  parameter int ADDR_W        = 48,
  parameter int MAX_OUT_LINES = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_ACCS-1:0]        acc_en,
  input  logic [NUM_ACCS-1:0]        acc_req_valid,
  input  logic [NUM_ACCS*ADDR_W-1:0] acc_req_addr,
  output logic [NUM_ACCS-1:0]        acc_req_ready,
  input  logic                       req_rd_available,
  output logic                       req_rd_en,
  output logic [ADDR_W-1:0]          req_rd_addr,
  output logic [15:0]                req_rd_mdata,
  input  logic                       resp_rd_valid,
  input  logic [511:0]               resp_rd_data,
  input  logic [15:0]                resp_rd_mdata,
  output logic [NUM_ACCS-1:0]        acc_resp_valid,
  output logic [511:0]               acc_resp_data,
  output logic [7:0]                 acc_resp_seq,
  output logic                       idle,
  output logic [1:0]                 err
);
  localparam int CW = $clog2(MAX_OUT_LINES + 1);
  localparam int PW = (NUM_ACCS > 1) ? $clog2(NUM_ACCS) : 1;
  // A requester may be granted only while outst <= MAX_OUT_LINES - 4.
  localparam logic [CW:0] LIM = (CW + 1)'(MAX_OUT_LINES - 4);

  logic [CW-1:0]       outst     [NUM_ACCS];
  logic [CW-1:0]       outst_nxt [NUM_ACCS];
  logic [7:0]          seq       [NUM_ACCS];
  logic [PW-1:0]       ptr;
  logic [PW-1:0]       gidx;
  logic [PW-1:0]       scan_idx;
  logic [NUM_ACCS-1:0] elig;
  logic [NUM_ACCS-1:0] resp_hit;
  logic                accept;
  logic [ADDR_W-1:0]   gaddr;
  logic [ID_W-1:0]     rid;
  logic                rid_ok;
  logic                underflow;
  logic                all_zero;
  logic                unused_id_bits;

  assign rid            = resp_rd_mdata[ID_W-1:0];
  assign rid_ok         = int'(rid) < NUM_ACCS;
  assign unused_id_bits = ^resp_rd_mdata[7:ID_W];

  always_comb begin
    for (int i = 0; i < NUM_ACCS; i++) begin
      elig[i] = acc_en[i] & acc_req_valid[i] & req_rd_available & ({1'b0, outst[i]} <= LIM);
    end
  end

  // Scan from the highest offset down so the requester closest to ptr wins.
  always_comb begin
    acc_req_ready = '0;
    gidx          = '0;
    scan_idx      = '0;
    accept        = 1'b0;
    for (int k = NUM_ACCS - 1; k >= 0; k--) begin
      scan_idx = PW'((int'(ptr) + k) % NUM_ACCS);
      if (elig[scan_idx]) begin
        acc_req_ready           = '0;
        acc_req_ready[scan_idx] = 1'b1;
        gidx                    = scan_idx;
        accept                  = 1'b1;
      end
    end
  end

  assign gaddr = acc_req_addr[int'(gidx)*ADDR_W +: ADDR_W];

  always_comb begin
    underflow = 1'b0;
    resp_hit  = '0;
    all_zero  = 1'b1;
    for (int i = 0; i < NUM_ACCS; i++) begin
      outst_nxt[i] = outst[i];
      if (accept && gidx == PW'(i)) outst_nxt[i] = outst_nxt[i] + CW'(4);
      if (resp_rd_valid && rid_ok && rid == ID_W'(i)) begin
        resp_hit[i] = 1'b1;
        if (outst[i] == '0) underflow = 1'b1;
        else outst_nxt[i] = outst_nxt[i] - CW'(1);
      end
      if (outst_nxt[i] != '0) all_zero = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_rd_en      <= 1'b0;
      req_rd_addr    <= '0;
      req_rd_mdata   <= '0;
      acc_resp_valid <= '0;
      acc_resp_data  <= '0;
      acc_resp_seq   <= '0;
      idle           <= 1'b1;
      err            <= '0;
      ptr            <= '0;
      for (int i = 0; i < NUM_ACCS; i++) begin
        outst[i] <= '0;
        seq[i]   <= '0;
      end
    end else begin
      req_rd_en      <= accept;
      acc_resp_valid <= resp_hit;
      idle           <= all_zero & ~accept;
      for (int i = 0; i < NUM_ACCS; i++) outst[i] <= outst_nxt[i];
      if (accept) begin
        req_rd_addr  <= {gaddr[ADDR_W-1:8], 8'h00};
        req_rd_mdata <= {seq[gidx], 8'(gidx)};
        seq[gidx]    <= seq[gidx] + 8'd1;
        ptr          <= (int'(gidx) == NUM_ACCS - 1) ? '0 : gidx + PW'(1);
        if (gaddr[7:0] != 8'h00) err[1] <= 1'b1;
      end
      if (resp_rd_valid && rid_ok) begin
        acc_resp_data <= resp_rd_data;
        acc_resp_seq  <= resp_rd_mdata[15:8];
      end
      if (underflow || (resp_rd_valid && !rid_ok)) err[0] <= 1'b1;
    end
  end
endmodule
